// File: rtl/uart_rx_if.sv
// Serial-receive bus: line and baud tick in, received word and status strobes out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_serial;
  logic                 baud_tick_16x;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 rx_busy;

  // Line/tick source and consumer of the received data
  modport master (
    output rx_serial, baud_tick_16x,
    input  rx_data, rx_valid, frame_err, rx_busy
  );

  // The receiver itself
  modport slave (
    input  rx_serial, baud_tick_16x,
    output rx_data, rx_valid, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with 3-sample mid-bit majority vote.
// Frames are start(0) + DATA_BITS (LSB first) + stop(1). DATA_BITS >= 2.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  uart_rx_if.slave bus
);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             tick_q;
  logic [BW-1:0]          bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   vote6_q, vote7_q;
  logic                   valid_q, err_q;
  logic                   rx_s, vote_d, mid_d, end_d;

  assign rx_s   = sync_q[SYNC_STAGES-1];
  // Majority of samples at tick_cnt 6, 7 and the live sample at 8
  assign vote_d = (vote6_q & vote7_q) | (vote6_q & rx_s) | (vote7_q & rx_s);
  assign mid_d  = bus.baud_tick_16x && (tick_q == 4'd8);
  assign end_d  = bus.baud_tick_16x && (tick_q == 4'd15);

  // Input synchroniser; idles high so reset does not look like a start edge
  always_ff @(posedge i_clk) begin
    if (i_rst) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx_serial};
  end

  // Frame FSM with tick counter, vote capture, shifter and registered strobes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vote6_q <= 1'b0;
      vote7_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      // Counter and vote samples run in every non-idle state
      if (state_q != IDLE && bus.baud_tick_16x) begin
        tick_q <= tick_q + 4'd1;
        if (tick_q == 4'd6) vote6_q <= rx_s;
        if (tick_q == 4'd7) vote7_q <= rx_s;
      end
      unique case (state_q)
        IDLE: begin
          // A tick coinciding with this transition is deliberately not counted
          if (!rx_s) begin
            state_q <= START;
            tick_q  <= '0;
          end
        end
        START: begin
          if (mid_d && vote_d) state_q <= IDLE;  // false start
          else if (end_d) begin
            state_q <= DATA;
            tick_q  <= '0;
            bit_q   <= '0;
          end
        end
        DATA: begin
          if (mid_d) shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
          if (end_d) begin
            if (bit_q == BW'(DATA_BITS - 1)) state_q <= STOP;
            else                             bit_q   <= bit_q + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid-stop so a drifting transmitter can start the next frame early
          if (mid_d) begin
            if (vote_d) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          // A break/stuck-low line must return high before a new frame is armed
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = err_q;
  assign bus.rx_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: per-tick line waveforms, majority-vote reference model.
module tb_uart_rx;
  logic clk, rst;
  int   checks, errors;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Monitor state
  logic [7:0] rxq[$];
  int         n_err, n_both, n_multi, busy_cnt;
  logic       prev_strobe;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 16x tick: one clock in every four, changed on the falling edge
  initial begin
    int ph;
    ph = 0;
    bus.baud_tick_16x = 1'b0;
    forever begin
      @(negedge clk);
      bus.baud_tick_16x = (ph == 0);
      ph = (ph + 1) % 4;
    end
  end

  // Output monitor, sampled on the falling edge
  initial begin
    prev_strobe = 1'b0;
    n_err = 0; n_both = 0; n_multi = 0; busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.rx_valid) rxq.push_back(bus.rx_data);
      if (bus.frame_err) n_err++;
      if (bus.rx_valid && bus.frame_err) n_both++;
      if ((bus.rx_valid || bus.frame_err) && prev_strobe) n_multi++;
      if (bus.rx_busy) busy_cnt++;
      prev_strobe = bus.rx_valid || bus.frame_err;
    end
  end

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a + b + c) >= 2;
  endfunction

  task automatic clr_mon();
    rxq.delete();
    n_err = 0;
    busy_cnt = 0;
  endtask

  // Wait for n ticks seen by the DUT, then step off the edge
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!bus.baud_tick_16x) @(posedge clk);
    end
    #1;
  endtask

  // lv[k] is the line level seen by the receiver's tick with tick_cnt==k
  task automatic play_bit(input logic [15:0] lv);
    for (int k = 0; k < 16; k++) begin
      bus.rx_serial = lv[k];
      wait_ticks(1);
    end
  endtask

  // Sends one frame; optional XOR glitch mask on one data bit; returns model byte
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int gbit,
                            input logic [15:0] gmask, output logic [7:0] exp_d);
    logic [15:0] lv;
    play_bit(16'h0000);
    for (int i = 0; i < 8; i++) begin
      lv = {16{d[i]}};
      if (i == gbit) lv = lv ^ gmask;
      exp_d[i] = maj3(lv[6], lv[7], lv[8]);
      play_bit(lv);
    end
    play_bit({16{stop_v}});
  endtask

  // Compares received-word queue against the expected list
  task automatic cmp_q(input string name, input logic [7:0] exp_q[$]);
    checks++;
    if (rxq.size() !== exp_q.size()) begin
      $display("FAIL %s: valid pulses got %0d expected %0d", name, rxq.size(), exp_q.size());
      errors++;
    end
    for (int i = 0; i < exp_q.size() && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== exp_q[i]) begin
        $display("FAIL %s[%0d]: data got %02h expected %02h", name, i, rxq[i], exp_q[i]);
        errors++;
      end
    end
  endtask

  logic [7:0] last_good;

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    checks += 4;
    if (bus.rx_data !== 8'h00) begin $display("FAIL reset_data: got %02h expected 00", bus.rx_data); errors++; end
    if (bus.rx_valid !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", bus.rx_valid); errors++; end
    if (bus.frame_err !== 1'b0) begin $display("FAIL reset_err: got %b expected 0", bus.frame_err); errors++; end
    if (bus.rx_busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", bus.rx_busy); errors++; end
    rst = 1'b0;
    last_good = 8'h00;
    wait_ticks(4);
  endtask

  task automatic test_basic();
    logic [7:0] e;
    logic [7:0] eq[$];
    clr_mon();
    send_frame(8'hA5, 1'b1, -1, 16'h0, e);
    wait_ticks(2);
    eq.push_back(e); last_good = e;
    cmp_q("basic_A5", eq);
    checks += 3;
    if (n_err !== 0) begin $display("FAIL basic_err: got %0d expected 0", n_err); errors++; end
    if (busy_cnt == 0) begin $display("FAIL basic_busy_seen: got %0d busy cycles expected >0", busy_cnt); errors++; end
    if (bus.rx_busy !== 1'b0) begin $display("FAIL basic_busy_end: got %b expected 0", bus.rx_busy); errors++; end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [7:0] eq[$];
    clr_mon();
    send_frame(8'h00, 1'b1, -1, 16'h0, e); eq.push_back(e);
    send_frame(8'hFF, 1'b1, -1, 16'h0, e); eq.push_back(e);
    wait_ticks(2);
    last_good = e;
    cmp_q("b2b", eq);
  endtask

  task automatic test_glitch();
    logic [7:0] eq[$];
    clr_mon();
    bus.rx_serial = 1'b0;
    wait_ticks(3);
    bus.rx_serial = 1'b1;
    checks++;
    if (bus.rx_busy !== 1'b1) begin $display("FAIL glitch_busy_start: got %b expected 1", bus.rx_busy); errors++; end
    wait_ticks(16);
    checks += 3;
    if (bus.rx_busy !== 1'b0) begin $display("FAIL glitch_busy_end: got %b expected 0", bus.rx_busy); errors++; end
    if (n_err !== 0) begin $display("FAIL glitch_err: got %0d expected 0", n_err); errors++; end
    if (bus.rx_data !== last_good) begin $display("FAIL glitch_data: got %02h expected %02h", bus.rx_data, last_good); errors++; end
    cmp_q("glitch", eq);
  endtask

  task automatic test_frame_err();
    logic [7:0] e;
    logic [7:0] eq[$];
    clr_mon();
    send_frame(8'h3C, 1'b0, -1, 16'h0, e);
    bus.rx_serial = 1'b0;
    wait_ticks(40);
    checks += 3;
    if (n_err !== 1) begin $display("FAIL ferr_count: got %0d expected 1", n_err); errors++; end
    if (bus.rx_data !== last_good) begin $display("FAIL ferr_data: got %02h expected %02h", bus.rx_data, last_good); errors++; end
    if (bus.rx_busy !== 1'b1) begin $display("FAIL ferr_wait_busy: got %b expected 1", bus.rx_busy); errors++; end
    cmp_q("ferr_novalid", eq);
    bus.rx_serial = 1'b1;
    wait_ticks(2);
    checks++;
    if (bus.rx_busy !== 1'b0) begin $display("FAIL ferr_release: got %b expected 0", bus.rx_busy); errors++; end
    clr_mon();
    send_frame(8'h5A, 1'b1, -1, 16'h0, e);
    wait_ticks(2);
    eq.push_back(e); last_good = e;
    cmp_q("ferr_recover", eq);
  endtask

  task automatic test_majority();
    logic [7:0] e;
    logic [7:0] eq[$];
    clr_mon();
    send_frame(8'h00, 1'b1, 3, 16'h0080, e); eq.push_back(e);
    send_frame(8'h00, 1'b1, 3, 16'h0180, e); eq.push_back(e);
    wait_ticks(2);
    last_good = e;
    cmp_q("majority", eq);
    checks++;
    if (e !== 8'h08) begin $display("FAIL majority_model: got %02h expected 08", e); errors++; end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    logic [7:0] eq[$];
    clr_mon();
    play_bit(16'h0000);
    for (int i = 0; i < 4; i++) play_bit({16{i[0]}});
    bus.rx_serial = 1'b1;
    wait_ticks(4);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks += 2;
    if (bus.rx_busy !== 1'b0) begin $display("FAIL rstmid_busy: got %b expected 0", bus.rx_busy); errors++; end
    if (bus.rx_data !== 8'h00) begin $display("FAIL rstmid_data: got %02h expected 00", bus.rx_data); errors++; end
    wait_ticks(20);
    checks++;
    if (n_err !== 0) begin $display("FAIL rstmid_err: got %0d expected 0", n_err); errors++; end
    cmp_q("rstmid_nopulse", eq);
    send_frame(8'h81, 1'b1, -1, 16'h0, e);
    wait_ticks(2);
    eq.push_back(e); last_good = e;
    cmp_q("rstmid_recover", eq);
  endtask

  task automatic test_random();
    logic [7:0] e, d;
    logic [7:0] eq[$];
    int gb;
    logic [15:0] gm;
    clr_mon();
    for (int n = 0; n < 10; n++) begin
      d  = 8'($urandom);
      gb = int'($urandom_range(0, 7));
      gm = ($urandom_range(0, 1) != 0) ? 16'(16'h1 << $urandom_range(6, 8)) : 16'h0;
      send_frame(d, 1'b1, gb, gm, e);
      eq.push_back(e);
      bus.rx_serial = 1'b1;
      wait_ticks(int'($urandom_range(0, 20)));
    end
    wait_ticks(2);
    last_good = e;
    cmp_q("random", eq);
    checks += 2;
    if (n_err !== 0) begin $display("FAIL random_err: got %0d expected 0", n_err); errors++; end
    if (bus.rx_data !== last_good) begin $display("FAIL random_hold: got %02h expected %02h", bus.rx_data, last_good); errors++; end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_majority();
    test_reset_mid();
    test_random();
    checks += 2;
    if (n_both !== 0) begin $display("FAIL strobe_overlap: got %0d expected 0", n_both); errors++; end
    if (n_multi !== 0) begin $display("FAIL strobe_width: got %0d long pulses expected 0", n_multi); errors++; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
